// File: rtl/sprite_line_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sprite_line_fetch : hblank sprite ROM fetch into a double-buffered line buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module sprite_line_fetch #(
  parameter int NUM_SPRITES = 8,
  parameter int LINE_W      = 224
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     line_start,
  input  logic [8:0]               next_row,
  input  logic [NUM_SPRITES*8-1:0] spr_col,
  input  logic [NUM_SPRITES*8-1:0] spr_row,
  input  logic [NUM_SPRITES*6-1:0] spr_num,
  input  logic [NUM_SPRITES-1:0]   spr_xflip,
  input  logic [NUM_SPRITES-1:0]   spr_yflip,
  input  logic [NUM_SPRITES*8-1:0] spr_pal,
  output logic [11:0]              rom_addr,
  input  logic [7:0]               rom_data,
  input  logic                     rd_en,
  input  logic [7:0]               rd_col,
  output logic [1:0]               pix_data,
  output logic [7:0]               pix_pal,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  localparam int            IW         = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NUM_SPRITES - 1);
  localparam logic [7:0]    C_INIT_TOP = 8'(LINE_W - 1);
  localparam logic [8:0]    C_LINE_W9  = 9'(LINE_W);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_SCAN, S_FETCH, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_init, w_init_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [1:0]    r_byte, w_byte_nxt;
  logic [1:0]    r_k, w_k_nxt;
  logic [3:0]    r_line;
  logic          r_front;
  logic [11:0]   r_rom_addr;
  logic [9:0]    r_pix;
  logic          r_overrun;

  // Shadow copy of the attribute table, taken at line_start
  logic [7:0] r_sh_next;
  logic [7:0] r_sh_col [NUM_SPRITES];
  logic [7:0] r_sh_row [NUM_SPRITES];
  logic [5:0] r_sh_num [NUM_SPRITES];
  logic       r_sh_xf  [NUM_SPRITES];
  logic       r_sh_yf  [NUM_SPRITES];
  logic [7:0] r_sh_pal [NUM_SPRITES];

  logic [9:0] r_buf [2][LINE_W];

  logic       w_latch, w_swap, w_set_ovr, w_line_load, w_addr_load, w_fetch_we;
  logic       w_hit, w_rd_hit;
  logic [8:0] w_row9, w_top9, w_col9;
  logic [3:0] w_diff, w_line, w_off;
  logic [1:0] w_code;
  logic       w_we [2];
  logic [7:0] w_wa [2];
  logic [9:0] w_wd [2];
  logic       w_unused;

  assign w_unused = next_row[8];

  // Hit test and row-in-sprite for the sprite under SCAN
  assign w_row9 = {1'b0, r_sh_next};
  assign w_top9 = {1'b0, r_sh_row[r_idx]};
  assign w_hit  = (w_row9 >= w_top9) && (w_row9 < (w_top9 + 9'd16));
  assign w_diff = r_sh_next[3:0] - r_sh_row[r_idx][3:0];
  assign w_line = r_sh_yf[r_idx] ? ~w_diff : w_diff;

  // Pixel unpack for the WRITE cycles
  assign w_code = rom_data[{r_k, 1'b0} +: 2];
  assign w_off  = r_sh_xf[r_idx] ? ~{r_byte, r_k} : {r_byte, r_k};
  assign w_col9 = {1'b0, r_sh_col[r_idx]} + {5'd0, w_off};

  assign w_rd_hit = rd_en && ({1'b0, rd_col} < C_LINE_W9);

  always_comb begin
    w_state_nxt = r_state;
    w_init_nxt  = r_init;
    w_idx_nxt   = r_idx;
    w_byte_nxt  = r_byte;
    w_k_nxt     = r_k;
    w_latch     = 1'b0;
    w_swap      = 1'b0;
    w_set_ovr   = 1'b0;
    w_line_load = 1'b0;
    w_addr_load = 1'b0;
    w_fetch_we  = 1'b0;
    case (r_state)
      S_INIT: begin
        w_init_nxt = r_init - 8'd1;
        if (r_init == 8'd0) w_state_nxt = S_IDLE;
      end
      S_IDLE, S_DONE: begin
        if (line_start) begin
          w_swap      = 1'b1;
          w_latch     = 1'b1;
          w_idx_nxt   = C_LAST_IDX;
          w_state_nxt = S_SCAN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SCAN: begin
        if (w_hit) begin
          w_line_load = 1'b1;
          w_byte_nxt  = 2'd0;
          w_state_nxt = S_FETCH;
        end else if (r_idx == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt = r_idx - IW'(1);
        end
      end
      S_FETCH: begin
        w_addr_load = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_k_nxt     = 2'd0;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_fetch_we = (w_code != 2'd0) && (w_col9 < C_LINE_W9);
        w_k_nxt    = r_k + 2'd1;
        if (r_k == 2'd3) begin
          if (r_byte != 2'd3) begin
            w_byte_nxt  = r_byte + 2'd1;
            w_state_nxt = S_FETCH;
          end else if (r_idx == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx - IW'(1);
            w_state_nxt = S_SCAN;
          end
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
    // A new line arriving mid-fetch abandons the partial line and restarts
    if (line_start && (r_state inside {S_SCAN, S_FETCH, S_WAIT, S_WRITE})) begin
      w_swap      = 1'b1;
      w_latch     = 1'b1;
      w_set_ovr   = 1'b1;
      w_fetch_we  = 1'b0;
      w_idx_nxt   = C_LAST_IDX;
      w_state_nxt = S_SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_init     <= C_INIT_TOP;
      r_idx      <= C_LAST_IDX;
      r_byte     <= 2'd0;
      r_k        <= 2'd0;
      r_line     <= 4'd0;
      r_front    <= 1'b0;
      r_rom_addr <= 12'd0;
      r_pix      <= 10'd0;
      r_overrun  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_init  <= w_init_nxt;
      r_idx   <= w_idx_nxt;
      r_byte  <= w_byte_nxt;
      r_k     <= w_k_nxt;
      if (w_line_load) r_line <= w_line;
      if (w_swap) r_front <= ~r_front;
      if (w_addr_load) r_rom_addr <= {r_sh_num[r_idx], r_line, r_byte};
      if (w_set_ovr) r_overrun <= 1'b1;
      if (rd_en) r_pix <= w_rd_hit ? r_buf[r_front][rd_col] : 10'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_sh_next <= next_row[7:0];
      for (int s = 0; s < NUM_SPRITES; s++) begin
        r_sh_col[s] <= spr_col[s*8 +: 8];
        r_sh_row[s] <= spr_row[s*8 +: 8];
        r_sh_num[s] <= spr_num[s*6 +: 6];
        r_sh_xf[s]  <= spr_xflip[s];
        r_sh_yf[s]  <= spr_yflip[s];
        r_sh_pal[s] <= spr_pal[s*8 +: 8];
      end
    end
  end

  // Front bank sees only clear-on-read, back bank only fetch writes
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_we[b] = 1'b0;
      w_wa[b] = 8'd0;
      w_wd[b] = 10'd0;
      if (r_state == S_INIT) begin
        w_we[b] = 1'b1;
        w_wa[b] = r_init;
      end else if (r_front == 1'(b)) begin
        w_we[b] = w_rd_hit;
        w_wa[b] = rd_col;
      end else begin
        w_we[b] = w_fetch_we;
        w_wa[b] = w_col9[7:0];
        w_wd[b] = {w_code, r_sh_pal[r_idx]};
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (w_we[b]) r_buf[b][w_wa[b]] <= w_wd[b];
    end
  end

  assign rom_addr = r_rom_addr;
  assign pix_data = r_pix[9:8];
  assign pix_pal  = r_pix[7:0];
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done     = (r_state == S_DONE);
  assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sprite_line_fetch : directed self-checking bench for sprite_line_fetch
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sprite_line_fetch;

  localparam int NS = 8;
  localparam int LW = 224;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          line_start;
  logic [8:0]    next_row;
  logic [NS*8-1:0] spr_col, spr_row, spr_pal;
  logic [NS*6-1:0] spr_num;
  logic [NS-1:0] spr_xflip, spr_yflip;
  logic [11:0]   rom_addr;
  logic [7:0]    rom_data;
  logic          rd_en;
  logic [7:0]    rd_col;
  logic [1:0]    pix_data;
  logic [7:0]    pix_pal;
  logic          busy, done, overrun;

  logic [7:0] rom_tab [64];
  int         addr_log [64];
  int         checks   = 0;
  int         failures = 0;

  sprite_line_fetch #(.NUM_SPRITES(NS), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .next_row(next_row),
    .spr_col(spr_col), .spr_row(spr_row), .spr_num(spr_num),
    .spr_xflip(spr_xflip), .spr_yflip(spr_yflip), .spr_pal(spr_pal),
    .rom_addr(rom_addr), .rom_data(rom_data), .rd_en(rd_en), .rd_col(rd_col),
    .pix_data(pix_data), .pix_pal(pix_pal), .busy(busy), .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: one byte per pattern number, same for every row/byte
  always @(posedge clk) rom_data <= rom_tab[rom_addr[11:6]];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_sprite(input int i, input int col, input int row, input int num,
                            input logic xf, input logic yf, input int pal);
    spr_col[i*8 +: 8] = 8'(col);
    spr_row[i*8 +: 8] = 8'(row);
    spr_num[i*6 +: 6] = 6'(num);
    spr_xflip[i]      = xf;
    spr_yflip[i]      = yf;
    spr_pal[i*8 +: 8] = 8'(pal);
  endtask

  task automatic run_line(input logic [8:0] row, output int cyc);
    next_row   = row;
    line_start = 1'b1;
    cyc        = 0;
    do begin
      tick;
      cyc++;
      line_start = 1'b0;
      if (cyc < 64) addr_log[cyc] = int'(rom_addr);
    end while (!done && cyc < 400);
    tick;
  endtask

  function automatic logic [9:0] exp_pix(input int tst, input int c);
    logic [1:0] code;
    logic [7:0] pal;
    code = 2'd0;
    pal  = 8'd0;
    case (tst)
      1: if (c >= 10 && c <= 25) begin code = 2'((c - 10) % 4); pal = 8'h07; end
      2: if (c >= 10 && c <= 25) begin code = 2'(3 - (c - 10) % 4); pal = 8'h07; end
      3: if (c >= 10 && c <= 25) begin
           code = 2'd3;
           pal  = (((c - 10) % 4) == 1) ? 8'h07 : 8'h33;
         end
      4: if (c >= 216 && c != 217) begin code = 2'((c - 216) % 4); pal = 8'h07; end
      5: if (c < 160 && (c % 40) < 16) begin code = 2'((c % 40) % 4); pal = 8'(16 + c / 40); end
      default: ;
    endcase
    return (code == 2'd0) ? 10'd0 : {code, pal};
  endfunction

  task automatic read_all(input int tst, input string tag);
    for (int c = 0; c < LW; c++) begin
      rd_col = 8'(c);
      rd_en  = 1'b1;
      tick;
      check($sformatf("%s[%0d]", tag, c), {22'd0, pix_data, pix_pal}, {22'd0, exp_pix(tst, c)});
    end
    rd_en  = 1'b0;
    rd_col = 8'd0;
  endtask

  initial begin
    int n;
    int cyc;
    int seen;
    int ovr_early;

    rst_n = 1'b0; line_start = 1'b0; next_row = 9'd0;
    rd_en = 1'b0; rd_col = 8'd0;
    for (int i = 0; i < 64; i++) rom_tab[i] = 8'h00;
    for (int i = 0; i < NS; i++) set_sprite(i, 0, 240, 0, 1'b0, 1'b0, 0);

    // Reset and INIT length
    repeat (3) tick;
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_ovr", overrun, 0);
    check("rst_pix", {pix_data, pix_pal}, 0);
    check("rst_addr", rom_addr, 0);
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 1000) begin n++; tick; end
    check("init_len", n, 224);
    read_all(0, "init_rd");

    // Single sprite, no flips
    rom_tab[5] = 8'hE4;
    set_sprite(0, 10, 20, 5, 1'b0, 1'b0, 8'h07);
    run_line(9'd23, cyc);
    check("t1_done_lat", cyc, 33);
    for (int b = 0; b < 4; b++) check($sformatf("t1_addr%0d", b), addr_log[10 + 6*b], 32'h14C + b);
    check("t1_ovr", overrun, 0);
    run_line(9'd100, cyc);
    check("t1_swap_lat", cyc, 9);
    read_all(1, "t1_rd");

    // Both flips
    set_sprite(0, 10, 20, 5, 1'b1, 1'b1, 8'h07);
    run_line(9'd23, cyc);
    check("t2_done_lat", cyc, 33);
    for (int b = 0; b < 4; b++) check($sformatf("t2_addr%0d", b), addr_log[10 + 6*b], 32'h170 + b);
    run_line(9'd100, cyc);
    read_all(2, "t2_rd");

    // Overlap priority: sprite 0 wins where opaque
    rom_tab[5] = 8'h0C;
    rom_tab[9] = 8'hFF;
    set_sprite(0, 10, 20, 5, 1'b0, 1'b0, 8'h07);
    set_sprite(3, 10, 20, 9, 1'b0, 1'b0, 8'h33);
    run_line(9'd23, cyc);
    check("t3_done_lat", cyc, 57);
    run_line(9'd100, cyc);
    read_all(3, "t3_rd");

    // Row boundaries
    set_sprite(3, 0, 240, 0, 1'b0, 1'b0, 0);
    run_line(9'd36, cyc);
    check("row_end_miss", cyc, 9);
    set_sprite(0, 10, 250, 5, 1'b0, 1'b0, 8'h07);
    run_line(9'd2, cyc);
    check("row_nowrap", cyc, 9);

    // Right-edge clip, clear-on-read, hold, out-of-range read
    rom_tab[5] = 8'hE4;
    set_sprite(0, 216, 20, 5, 1'b0, 1'b0, 8'h07);
    run_line(9'd23, cyc);
    check("t4_done_lat", cyc, 33);
    run_line(9'd100, cyc);
    rd_col = 8'd217; rd_en = 1'b1;
    tick;
    check("t4_rd217", {pix_data, pix_pal}, 10'h107);
    rd_en = 1'b0; rd_col = 8'd0;
    tick;
    check("t4_hold", {pix_data, pix_pal}, 10'h107);
    rd_col = 8'd217; rd_en = 1'b1;
    tick;
    check("t4_reread", {pix_data, pix_pal}, 0);
    rd_col = 8'd230;
    tick;
    check("t4_oob", {pix_data, pix_pal}, 0);
    rd_en = 1'b0;
    read_all(4, "t4_rd");

    // Overrun: second line_start 50 cycles into a 4-hit fetch
    for (int s = 0; s < 4; s++) set_sprite(s, 40*s, 20, 5, 1'b0, 1'b0, 16 + s);
    next_row = 9'd23; line_start = 1'b1; seen = 0;
    for (int k = 1; k <= 50; k++) begin
      tick;
      line_start = 1'b0;
      if (done) seen = 1;
    end
    line_start = 1'b1; cyc = 0; ovr_early = 0;
    do begin
      tick;
      cyc++;
      line_start = 1'b0;
      if (cyc == 1) ovr_early = int'(overrun);
    end while (!done && cyc < 400);
    tick;
    check("ovr_no_done", seen, 0);
    check("ovr_set", ovr_early, 1);
    check("ovr_done_lat", cyc, 105);
    check("ovr_sticky", overrun, 1);
    run_line(9'd100, cyc);
    read_all(5, "t5_rd");
    check("ovr_sticky2", overrun, 1);

    // Reset mid-fetch; line_start during INIT is ignored
    next_row = 9'd23; line_start = 1'b1;
    tick;
    line_start = 1'b0;
    repeat (19) tick;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    tick;
    check("rst2_ovr", overrun, 0);
    check("rst2_busy", busy, 1);
    check("rst2_addr", rom_addr, 0);
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 1000) begin
      n++;
      line_start = (n == 5);
      tick;
    end
    line_start = 1'b0;
    check("init2_len", n, 224);
    check("init2_ovr", overrun, 0);
    read_all(0, "rst_bank_a");
    run_line(9'd100, cyc);
    check("rst_swap_lat", cyc, 9);
    read_all(0, "rst_bank_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
